// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-lite constants, master state enum and request-capture types
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} mst_state_e;
  typedef struct packed {
    logic       write;
    logic [2:0] size;
  } req_ctl_s;
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
    return (size > HSIZE_WORD) || (size == HSIZE_HALF && a[0]) || (size == HSIZE_WORD && a != 2'b00);
  endfunction
endpackage

// File: rtl/ahb_master_wdog.sv
// ahb_master_wdog: counts consecutive hready-low cycles while enabled, flags the CYCLES-th one
module ahb_master_wdog #(
  parameter int unsigned CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic hready_i,
  output logic expired_o
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d     = (!en_i || hready_i) ? '0 : cnt_q + 1'b1;
  assign expired_o = en_i && !hready_i && (cnt_q == CW'(CYCLES - 1));
  always_ff @(posedge clk_i) begin
    cnt_q <= rst_i ? '0 : cnt_d;
  end
endmodule

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-outstanding AHB-lite master, one SINGLE NONSEQ transfer per request.
// Optional wait-state timeout under AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int unsigned HADDR_WIDTH    = 32,
  parameter int unsigned HDATA_WIDTH    = 32,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [HADDR_WIDTH-1:0] req_addr_i,
  input  logic [2:0]             req_size_i,
  input  logic [HDATA_WIDTH-1:0] req_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [HDATA_WIDTH-1:0] rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic [HADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]             htrans_o,
  output logic                   hwrite_o,
  output logic [2:0]             hsize_o,
  output logic [2:0]             hburst_o,
  output logic [3:0]             hprot_o,
  output logic                   hmastlock_o,
  output logic [HDATA_WIDTH-1:0] hwdata_o,
  input  logic                   hready_i,
  input  logic [1:0]             hresp_i,
  input  logic [HDATA_WIDTH-1:0] hrdata_i
);
  mst_state_e             state_q, state_d;
  req_ctl_s               ctl_q, ctl_d;
  logic [HADDR_WIDTH-1:0] addr_q, addr_d;
  logic [HDATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   timeout, fault;
`ifdef AHB_MASTER_TIMEOUT_EN
  logic fault_q, fault_d;
  ahb_master_wdog #(.CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (state_q == ST_ADDR || state_q == ST_DATA),
    .hready_i  (hready_i),
    .expired_o (timeout)
  );
  // a timed-out slave may still own the bus, so refuse new work until reset
  assign fault_d = fault_q | timeout;
  assign fault   = fault_q;
  always_ff @(posedge clk_i) begin
    fault_q <= rst_i ? 1'b0 : fault_d;
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (req_valid_i && !fault) begin
        ctl_d   = '{write: req_write_i, size: req_size_i};
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        rdata_d = '0;
        err_d   = misaligned(req_size_i, req_addr_i[1:0]);
        state_d = err_d ? ST_RESP : ST_ADDR;
      end
      ST_ADDR: if (timeout) begin
        err_d   = 1'b1;
        state_d = ST_RESP;
      end else if (hready_i) begin
        state_d = ST_DATA;
      end
      ST_DATA: if (timeout) begin
        err_d   = 1'b1;
        state_d = ST_RESP;
      end else if (hready_i) begin
        rdata_d = ctl_q.write ? '0 : hrdata_i;
        err_d   = |hresp_i;
        state_d = ST_RESP;
      end
      default: state_d = rsp_ready_i ? ST_IDLE : ST_RESP;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign req_ready_o = (state_q == ST_IDLE) && !rst_i && !fault;
  assign htrans_o    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o     = (state_q == ST_ADDR) ? addr_q : '0;
  assign hwrite_o    = (state_q == ST_ADDR) && ctl_q.write;
  assign hsize_o     = (state_q == ST_ADDR) ? ctl_q.size : 3'd0;
  assign hwdata_o    = (state_q == ST_DATA) ? wdata_q : '0;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : '0;
  assign rsp_error_o = (state_q == ST_RESP) && err_q;
  assign hburst_o    = HBURST_SINGLE;
  assign hprot_o     = HPROT_VAL;
  assign hmastlock_o = 1'b0;
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed + randomized transactions against a transaction-level model
module tb_ahb_lite_master;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic [2:0]  req_size_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_error_o;
  logic [31:0] rsp_rdata_o, haddr_o, hwdata_o, hrdata_i = '0;
  logic [1:0]  htrans_o, hresp_i = '0;
  logic        hwrite_o, hmastlock_o, hready_i = 1'b1;
  logic [2:0]  hsize_o, hburst_o;
  logic [3:0]  hprot_o;
  int checks = 0, errors = 0, cyc = 0;

  ahb_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o), .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
    .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o),
    .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  function automatic logic illegal(input logic [2:0] size, input logic [31:0] a);
    return size > 3'd2 || (size == 3'd1 && a[0]) || (size == 3'd2 && a[1:0] != 2'b00);
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rdy"}, req_ready_o, 1'b0);
    chk({tag, "_rv"}, rsp_valid_o, 1'b0);
    chk({tag, "_rd"}, rsp_rdata_o, 32'h0);
    chk({tag, "_re"}, rsp_error_o, 1'b0);
    chk({tag, "_ha"}, haddr_o, 32'h0);
    chk({tag, "_ht"}, htrans_o, 2'b00);
    chk({tag, "_hw"}, hwrite_o, 1'b0);
    chk({tag, "_hs"}, hsize_o, 3'd0);
    chk({tag, "_hd"}, hwdata_o, 32'h0);
    chk({tag, "_hp"}, hprot_o, 4'b0011);
    chk({tag, "_hb"}, hburst_o, 3'b000);
    chk({tag, "_hl"}, hmastlock_o, 1'b0);
  endtask

  // called at a negedge with the master idle; returns at the negedge after the response handshake
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wd, input int aw, input int dw, input logic serr,
                     input logic [31:0] rd, input int hold);
    int t0;
    logic bad;
    logic [31:0] exp_rd;
    logic exp_err;
    bad = illegal(size, addr);
    exp_err = bad || serr;
    exp_rd = (bad || wr) ? 32'h0 : rd;
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_size_i = size; req_wdata_i = wd;
    chk("acc_rdy", req_ready_o, 1'b1);
    t0 = cyc;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom; req_write_i = ~wr;
    if (!bad) begin
      for (int i = 0; i <= aw; i++) begin
        hready_i = (i == aw); hresp_i = 2'b00; hrdata_i = $urandom;
        chk("a_trans", htrans_o, 2'b10);
        chk("a_addr", haddr_o, addr);
        chk("a_write", hwrite_o, wr);
        chk("a_size", hsize_o, size);
        @(negedge clk_i);
      end
      for (int j = 0; j <= dw; j++) begin
        hready_i = (j == dw);
        hresp_i = (serr && j >= dw - 1) ? 2'b11 : 2'b00;
        hrdata_i = (j == dw) ? rd : $urandom;
        chk("d_trans", htrans_o, 2'b00);
        chk("d_wdata", hwdata_o, wd);
        @(negedge clk_i);
      end
      hready_i = 1'b1; hresp_i = 2'b00;
    end
    chk("lat", cyc - t0, bad ? 1 : 3 + aw + dw);
    for (int k = 0; k <= hold; k++) begin
      rsp_ready_i = (k == hold);
      req_valid_i = 1'b1; req_addr_i = $urandom; req_size_i = 3'($urandom);
      chk("r_valid", rsp_valid_o, 1'b1);
      chk("r_err", rsp_error_o, exp_err);
      chk("r_data", rsp_rdata_o, exp_rd);
      chk("r_rdy", req_ready_o, 1'b0);
      chk("r_trans", htrans_o, 2'b00);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0; req_valid_i = 1'b0;
    chk("post_valid", rsp_valid_o, 1'b0);
    chk("post_rdy", req_ready_o, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check_idle_outputs("rst");
    rst_i = 1'b0;
    @(negedge clk_i);
    txn(1'b1, 32'h8, 3'd2, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h4, 3'd2, 32'h0, 0, 3, 1'b0, 32'h12345678, 0);
    txn(1'b0, 32'h2, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h20, 3'd2, 32'h0, 0, 1, 1'b1, 32'hAAAA5555, 0);
    txn(1'b0, 32'hC, 3'd2, 32'h0, 1, 0, 1'b0, 32'h0BADF00D, 5);
    txn(1'b1, 32'h3, 3'd1, 32'h1, 0, 0, 1'b0, 32'h0, 1);
    txn(1'b0, 32'h6, 3'd1, 32'h0, 2, 2, 1'b0, 32'h00C0FFEE, 0);
    txn(1'b0, 32'h7, 3'd0, 32'h0, 0, 0, 1'b0, 32'h000000A5, 0);
    txn(1'b1, 32'h0, 3'd3, 32'h5, 0, 0, 1'b0, 32'h0, 0);
    for (int n = 0; n < 40; n++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      txn(1'($urandom), $urandom, sz, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3));
    end
    // reset during the data phase
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h40; req_size_i = 3'd2; req_wdata_i = 32'hCAFE0001;
    @(negedge clk_i);
    req_valid_i = 1'b0; hready_i = 1'b1;
    @(negedge clk_i);
    chk("md_wdata", hwdata_o, 32'hCAFE0001);
    hready_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    check_idle_outputs("md");
    rst_i = 1'b0; hready_i = 1'b1;
    @(negedge clk_i);
    chk("md_rdy", req_ready_o, 1'b1);
    chk("md_trans", htrans_o, 2'b00);
`ifdef AHB_MASTER_TIMEOUT_EN
    begin
      int t0;
      bit seen;
      seen = 1'b0;
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h10; req_size_i = 3'd2;
      t0 = cyc;
      @(negedge clk_i);
      req_valid_i = 1'b0; hready_i = 1'b0; hrdata_i = 32'hFFFFFFFF;
      for (int w = 0; w < 40 && !seen; w++) begin
        if (rsp_valid_o) seen = 1'b1;
        else @(negedge clk_i);
      end
      chk("tmo_seen", seen, 1'b1);
      chk("tmo_lat", cyc - t0, 17);
      chk("tmo_err", rsp_error_o, 1'b1);
      chk("tmo_data", rsp_rdata_o, 32'h0);
      chk("tmo_trans", htrans_o, 2'b00);
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk("tmo_fault_rdy", req_ready_o, 1'b0);
      rst_i = 1'b1; hready_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("tmo_recover", req_ready_o, 1'b1);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
